// File: rtl/ifft4_pkg.sv
// Shared constants and FSM encoding for the 4-point streaming inverse FFT.
package ifft4_pkg;

  localparam int N_POINTS = 4;
  localparam int LOG2N    = 2;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    BFLY1   = 2'd1,
    BFLY2   = 2'd2,
    EMIT    = 2'd3
  } state_t;

endpackage

// File: rtl/ifft4_butterfly.sv
// Combinational radix-2 add/sub pair; when ROT_J=1 the b leg is rotated by +j first.
module ifft4_butterfly #(
  parameter int W     = 35,
  parameter bit ROT_J = 1'b0
) (
  input  logic signed [W-1:0] a_re,
  input  logic signed [W-1:0] a_im,
  input  logic signed [W-1:0] b_re,
  input  logic signed [W-1:0] b_im,
  output logic signed [W:0]   s_re,
  output logic signed [W:0]   s_im,
  output logic signed [W:0]   d_re,
  output logic signed [W:0]   d_im
);

  logic signed [W:0] ar, ai, br, bi, tr, ti;

  always_comb begin
    ar = {a_re[W-1], a_re};
    ai = {a_im[W-1], a_im};
    br = {b_re[W-1], b_re};
    bi = {b_im[W-1], b_im};
    // j*(br + j*bi) = -bi + j*br; negation is safe at W+1 bits
    if (ROT_J) begin
      tr = -bi;
      ti = br;
    end else begin
      tr = br;
      ti = bi;
    end
    s_re = ar + tr;
    s_im = ai + ti;
    d_re = ar - tr;
    d_im = ai - ti;
  end

endmodule

// File: rtl/ifft_4_point.sv
// Streaming 4-point radix-2 DIT inverse FFT: collect 4 bins, two registered
// butterfly stages, then emit x0..x3 serially with out_last on x3.
module ifft_4_point
  import ifft4_pkg::*;
#(
  parameter int IN_W  = 35,
  parameter bit SCALE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IN_W-1:0] in_re,
  input  logic signed [IN_W-1:0] in_im,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [IN_W+1:0] out_re,
  output logic signed [IN_W+1:0] out_im,
  output logic                   out_last
);

  localparam int AW = IN_W + 1;
  localparam int OW = IN_W + 2;

  // Handshakes: a transfer occurs on a rising edge where valid and ready are
  // both high; valid never waits on ready and data holds while valid&!ready.

  state_t            state;
  logic [1:0]        in_cnt;
  logic [1:0]        out_cnt;

  logic signed [IN_W-1:0] x_re [N_POINTS];
  logic signed [IN_W-1:0] x_im [N_POINTS];
  // Stage-1 order: a0, a1, b0, b1
  logic signed [AW-1:0]   s1_re [N_POINTS];
  logic signed [AW-1:0]   s1_im [N_POINTS];
  logic signed [AW-1:0]   st1_re [N_POINTS];
  logic signed [AW-1:0]   st1_im [N_POINTS];
  // Stage-2 order: y0, y1, y2, y3
  logic signed [OW-1:0]   s2_re [N_POINTS];
  logic signed [OW-1:0]   s2_im [N_POINTS];
  logic signed [OW-1:0]   y_re [N_POINTS];
  logic signed [OW-1:0]   y_im [N_POINTS];

  ifft4_butterfly #(.W(IN_W), .ROT_J(1'b0)) u_s1_even (
    .a_re(x_re[0]), .a_im(x_im[0]), .b_re(x_re[2]), .b_im(x_im[2]),
    .s_re(s1_re[0]), .s_im(s1_im[0]), .d_re(s1_re[1]), .d_im(s1_im[1])
  );

  ifft4_butterfly #(.W(IN_W), .ROT_J(1'b0)) u_s1_odd (
    .a_re(x_re[1]), .a_im(x_im[1]), .b_re(x_re[3]), .b_im(x_im[3]),
    .s_re(s1_re[2]), .s_im(s1_im[2]), .d_re(s1_re[3]), .d_im(s1_im[3])
  );

  ifft4_butterfly #(.W(AW), .ROT_J(1'b0)) u_s2_dc (
    .a_re(st1_re[0]), .a_im(st1_im[0]), .b_re(st1_re[2]), .b_im(st1_im[2]),
    .s_re(s2_re[0]), .s_im(s2_im[0]), .d_re(s2_re[2]), .d_im(s2_im[2])
  );

  ifft4_butterfly #(.W(AW), .ROT_J(1'b1)) u_s2_rot (
    .a_re(st1_re[1]), .a_im(st1_im[1]), .b_re(st1_re[3]), .b_im(st1_im[3]),
    .s_re(s2_re[1]), .s_im(s2_im[1]), .d_re(s2_re[3]), .d_im(s2_im[3])
  );

  // 1/N as an arithmetic shift: rounds toward -inf
  function automatic logic signed [OW-1:0] scl(input logic signed [OW-1:0] v);
    return SCALE ? (v >>> LOG2N) : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      in_cnt    <= 2'd0;
      out_cnt   <= 2'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      for (int i = 0; i < N_POINTS; i++) begin
        x_re[i]   <= '0;
        x_im[i]   <= '0;
        st1_re[i] <= '0;
        st1_im[i] <= '0;
        y_re[i]   <= '0;
        y_im[i]   <= '0;
      end
    end else begin
      case (state)
        COLLECT: begin
          if (in_valid && in_ready) begin
            x_re[in_cnt] <= in_re;
            x_im[in_cnt] <= in_im;
            in_cnt       <= in_cnt + 2'd1;
            if (in_cnt == 2'd3) begin
              in_ready <= 1'b0;
              state    <= BFLY1;
            end
          end
        end
        BFLY1: begin
          for (int i = 0; i < N_POINTS; i++) begin
            st1_re[i] <= s1_re[i];
            st1_im[i] <= s1_im[i];
          end
          state <= BFLY2;
        end
        BFLY2: begin
          for (int i = 0; i < N_POINTS; i++) begin
            y_re[i] <= scl(s2_re[i]);
            y_im[i] <= scl(s2_im[i]);
          end
          out_re    <= scl(s2_re[0]);
          out_im    <= scl(s2_im[0]);
          out_valid <= 1'b1;
          out_last  <= 1'b0;
          out_cnt   <= 2'd0;
          state     <= EMIT;
        end
        EMIT: begin
          if (out_valid && out_ready) begin
            if (out_cnt == 2'd3) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_cnt   <= 2'd0;
              in_ready  <= 1'b1;
              state     <= COLLECT;
            end else begin
              out_cnt  <= out_cnt + 2'd1;
              out_re   <= y_re[out_cnt + 2'd1];
              out_im   <= y_im[out_cnt + 2'd1];
              out_last <= (out_cnt == 2'd2);
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_ifft_4_point.sv
// Directed + random bench for ifft_4_point: a scaled and an unscaled instance
// share stimulus; a DFT-based model fills per-instance expected queues.
module tb_ifft_4_point;

  localparam int IN_W = 35;
  localparam int OW   = IN_W + 2;
  localparam int PW   = 2 * OW + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic signed [IN_W-1:0] in_re = '0;
  logic signed [IN_W-1:0] in_im = '0;

  logic ir [2];
  logic ov [2];
  logic ol [2];
  logic signed [OW-1:0] ore [2];
  logic signed [OW-1:0] oim [2];

  // index 0: SCALE=1 instance, index 1: SCALE=0 instance
  logic [PW-1:0] exp_q0[$];
  logic [PW-1:0] exp_q1[$];
  longint fr_re [4];
  longint fr_im [4];

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  ifft_4_point #(.IN_W(IN_W), .SCALE(1'b1)) u_scaled (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
    .in_re(in_re), .in_im(in_im), .out_valid(ov[0]), .out_ready(out_ready),
    .out_re(ore[0]), .out_im(oim[0]), .out_last(ol[0])
  );

  ifft_4_point #(.IN_W(IN_W), .SCALE(1'b0)) u_raw (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
    .in_re(in_re), .in_im(in_im), .out_valid(ov[1]), .out_ready(out_ready),
    .out_re(ore[1]), .out_im(oim[1]), .out_last(ol[1])
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      $error("assertion on %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- model: x[n] = sum_k X[k] * j^(n*k), optionally /4 ----------------
  task automatic push_frame();
    longint sr, si, sc_r, sc_i;
    logic [OW-1:0] a, b;
    for (int n = 0; n < 4; n++) begin
      sr = 0;
      si = 0;
      for (int k = 0; k < 4; k++) begin
        case ((n * k) % 4)
          0: begin sr += fr_re[k]; si += fr_im[k]; end
          1: begin sr -= fr_im[k]; si += fr_re[k]; end
          2: begin sr -= fr_re[k]; si -= fr_im[k]; end
          default: begin sr += fr_im[k]; si -= fr_re[k]; end
        endcase
      end
      sc_r = sr >>> 2;
      sc_i = si >>> 2;
      a = sc_r[OW-1:0];
      b = sc_i[OW-1:0];
      exp_q0.push_back({(n == 3), a, b});
      a = sr[OW-1:0];
      b = si[OW-1:0];
      exp_q1.push_back({(n == 3), a, b});
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [PW-1:0] held [2];
  bit            hold_pend [2];
  logic [PW-1:0] got_m, exp_m;
  bit            has_m;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        hold_pend[d] = 1'b0;
      end else begin
        got_m = {ol[d], ore[d], oim[d]};
        if (hold_pend[d]) begin
          check($sformatf("hold_valid_%0d", d), ov[d], 1);
          check($sformatf("hold_data_%0d", d), got_m, held[d]);
        end
        if (!ov[d]) check($sformatf("last_idle_%0d", d), ol[d], 0);
        if (ov[d] && out_ready) begin
          has_m = (d == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
          check($sformatf("has_expected_%0d", d), has_m, 1);
          if (has_m) begin
            if (d == 0) exp_m = exp_q0.pop_front();
            else        exp_m = exp_q1.pop_front();
            check($sformatf("sample_%0d", d), got_m, exp_m);
          end
        end
        hold_pend[d] = ov[d] && !out_ready;
        held[d]      = got_m;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_frame(input bit gaps);
    int g;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_re = fr_re[i][IN_W-1:0];
      in_im = fr_im[i][IN_W-1:0];
      g = 0;
      while (!ir[0] && g < 100) begin
        tick();
        g++;
      end
      check("in_ready_wait", (g < 100), 1);
      if (i == 3) push_frame();
      tick();
      in_valid = 1'b0;
      if (gaps && (i == 0 || i == 2)) tick();
    end
    check("ready_low_after_frame", ir[0], 0);
    check("ovalid_edge_n", ov[0], 0);
    tick();
    check("ovalid_edge_n1", ov[0], 0);
    tick();
    check("ovalid_edge_n2_s", ov[0], 1);
    check("ovalid_edge_n2_r", ov[1], 1);
  endtask

  task automatic wait_drain(input bit rnd_ready);
    int g;
    g = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && g < 300) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      tick();
      g++;
    end
    out_ready = 1'b1;
    check("drain_done", (g < 300), 1);
    check("ready_back_s", ir[0], 1);
    check("ready_back_r", ir[1], 1);
    check("ovalid_idle", ov[0], 0);
  endtask

  task automatic set_frame(input longint r0, input longint i0, input longint r1, input longint i1,
                           input longint r2, input longint i2, input longint r3, input longint i3);
    fr_re[0] = r0; fr_im[0] = i0;
    fr_re[1] = r1; fr_im[1] = i1;
    fr_re[2] = r2; fr_im[2] = i2;
    fr_re[3] = r3; fr_im[3] = i3;
  endtask

  task automatic rand_frame();
    logic signed [IN_W-1:0] t;
    for (int i = 0; i < 4; i++) begin
      t = IN_W'({$urandom(), $urandom()});
      fr_re[i] = longint'(t);
      t = IN_W'({$urandom(), $urandom()});
      fr_im[i] = longint'(t);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    longint mn;
    rst = 1'b1;
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      check("rst_in_ready", ir[d], 1);
      check("rst_out_valid", ov[d], 0);
      check("rst_out_last", ol[d], 0);
      check("rst_out_re", ore[d], 0);
      check("rst_out_im", oim[d], 0);
    end
    rst = 1'b0;
    tick();

    // ramp reconstruction
    set_frame(6, 0, -2, 2, -2, 0, -2, -2);
    send_frame(1'b0);
    wait_drain(1'b0);

    // unscaled vs scaled sums
    set_frame(2, 0, 1, -1, 0, 0, 1, 1);
    send_frame(1'b0);
    wait_drain(1'b0);

    // backpressure while x1 is presented
    rand_frame();
    send_frame(1'b0);
    tick();
    out_ready = 1'b0;
    repeat (3) begin
      tick();
      check("bp_in_ready", ir[0], 0);
      check("bp_out_valid", ov[0], 1);
    end
    out_ready = 1'b1;
    wait_drain(1'b0);

    // input gaps, then in_valid held during EMIT with junk data
    rand_frame();
    send_frame(1'b1);
    in_valid = 1'b1;
    in_re = 35'h1_2345_6789;
    in_im = 35'h7_0F0F_0F0F;
    wait_drain(1'b0);
    in_valid = 1'b0;
    rand_frame();
    send_frame(1'b0);
    wait_drain(1'b0);

    // reset mid-EMIT after x1
    rand_frame();
    send_frame(1'b0);
    tick();
    tick();
    rst = 1'b1;
    exp_q0.delete();
    exp_q1.delete();
    tick();
    rst = 1'b0;
    check("mid_rst_ovalid_s", ov[0], 0);
    check("mid_rst_ovalid_r", ov[1], 0);
    check("mid_rst_in_ready", ir[0], 1);
    check("mid_rst_last", ol[0], 0);
    set_frame(4, 0, 0, 0, 0, 0, 0, 0);
    send_frame(1'b0);
    wait_drain(1'b0);

    // most negative bins: exact without wrap
    mn = -(longint'(1) << (IN_W - 1));
    set_frame(mn, mn, mn, mn, mn, mn, mn, mn);
    send_frame(1'b0);
    wait_drain(1'b0);

    // random frames with random downstream stalls
    for (int f = 0; f < 4; f++) begin
      rand_frame();
      send_frame(f[0]);
      wait_drain(1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
